// File: rtl/stopwatch_seconds_stage_if.sv
// Command/status bundle between the stopwatch control and the seconds stage.
// Latency: none, plain wires.
// Backpressure: none; commands are single-cycle pulses, status is level/pulse.
interface stopwatch_seconds_stage_if;
  logic       start;
  logic       stop;
  logic       clear;
  logic [5:0] sec_count;
  logic       min_enable;
  logic       clear_out;
  logic       running;

  // Command source side (control logic or bench)
  modport master (
    output start, stop, clear,
    input  sec_count, min_enable, clear_out, running
  );

  // Seconds stage side
  modport slave (
    input  start, stop, clear,
    output sec_count, min_enable, clear_out, running
  );
endinterface

// File: rtl/stopwatch_seconds_stage.sv
// Run-control FSM, clock prescaler and 0-59 seconds counter feeding the minutes stage.
// Latency: commands act on the edge that samples them; counting starts the edge after start.
// Backpressure: none; every command pulse is accepted, all outputs are registered.
module stopwatch_seconds_stage #(
  parameter int TICKS_PER_SEC = 100000000,
  parameter int PRESC_W       = $clog2(TICKS_PER_SEC)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  stopwatch_seconds_stage_if.slave  io
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUNNING = 2'd1,
    S_PAUSED  = 2'd2
  } state_t;

  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICKS_PER_SEC - 1);
  localparam logic [PRESC_W-1:0] PRESC_ONE = PRESC_W'(1);

  state_t             r_state;
  logic [PRESC_W-1:0] r_presc;
  logic [5:0]         r_sec;
  logic               r_min_enable;
  logic               r_clear_out;
  logic               r_running;

  logic               w_last_tick;
  logic               w_last_sec;

  assign w_last_tick = (r_presc == PRESC_MAX);
  assign w_last_sec  = (r_sec == 6'd59);

  // FSM, prescaler and seconds counter in one block so clear/stop can veto the advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_presc      <= '0;
      r_sec        <= 6'd0;
      r_min_enable <= 1'b0;
      r_clear_out  <= 1'b0;
      r_running    <= 1'b0;
    end else if (io.clear) begin
      // clear beats everything, including a wrap on this same edge
      r_state      <= S_IDLE;
      r_presc      <= '0;
      r_sec        <= 6'd0;
      r_min_enable <= 1'b0;
      r_clear_out  <= 1'b1;
      r_running    <= 1'b0;
    end else begin
      r_clear_out  <= 1'b0;
      r_min_enable <= 1'b0;
      case (r_state)
        S_IDLE, S_PAUSED: begin
          // stop is meaningless here, so start applies even if both arrive
          if (io.start) begin
            r_state   <= S_RUNNING;
            r_running <= 1'b1;
          end
        end
        S_RUNNING: begin
          if (io.stop) begin
            // prescaler frozen: the partial second survives the pause
            r_state   <= S_PAUSED;
            r_running <= 1'b0;
          end else if (w_last_tick) begin
            r_presc <= '0;
            if (w_last_sec) begin
              r_sec        <= 6'd0;
              r_min_enable <= 1'b1;
            end else begin
              r_sec <= r_sec + 6'd1;
            end
          end else begin
            r_presc <= r_presc + PRESC_ONE;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_running <= 1'b0;
        end
      endcase
    end
  end

  assign io.sec_count  = r_sec;
  assign io.min_enable = r_min_enable;
  assign io.clear_out  = r_clear_out;
  assign io.running    = r_running;

endmodule

// File: tb/tb_stopwatch_seconds_stage.sv
// Bench for the seconds stage: directed scenarios plus random command traffic.
// Latency: one check set per clock edge, sampled 1 time unit after the edge.
// Backpressure: not applicable.
module tb_stopwatch_seconds_stage;

  localparam int T = 4;
  localparam int M_IDLE    = 0;
  localparam int M_RUNNING = 1;
  localparam int M_PAUSED  = 2;

  logic clk;
  logic rst_n;

  stopwatch_seconds_stage_if bus ();

  stopwatch_seconds_stage #(.TICKS_PER_SEC(T)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int me_seen = 0;

  // Reference model: elapsed counted ticks since the last clear/reset
  int   m_mode    = M_IDLE;
  int   m_elapsed = 0;
  logic m_me      = 1'b0;
  logic m_clr     = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode    = M_IDLE;
    m_elapsed = 0;
    m_me      = 1'b0;
    m_clr     = 1'b0;
  endtask

  task automatic model_edge(input logic s, input logic p, input logic c);
    m_me  = 1'b0;
    m_clr = 1'b0;
    if (c) begin
      m_mode    = M_IDLE;
      m_elapsed = 0;
      m_clr     = 1'b1;
    end else begin
      if (m_mode == M_RUNNING && !p) begin
        m_elapsed++;
        if (m_elapsed % (60 * T) == 0) m_me = 1'b1;
      end
      if (p && m_mode == M_RUNNING)      m_mode = M_PAUSED;
      else if (s && m_mode != M_RUNNING) m_mode = M_RUNNING;
    end
  endtask

  task automatic model_check();
    chk("sec_count",  32'(bus.sec_count),  32'((m_elapsed / T) % 60));
    chk("min_enable", 32'(bus.min_enable), 32'(m_me));
    chk("clear_out",  32'(bus.clear_out),  32'(m_clr));
    chk("running",    32'(bus.running),    32'(m_mode == M_RUNNING));
  endtask

  task automatic step(input logic s, input logic p, input logic c);
    @(negedge clk);
    bus.start = s;
    bus.stop  = p;
    bus.clear = c;
    @(posedge clk);
    model_edge(s, p, c);
    #1;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    bus.clear = 1'b0;
    if (bus.min_enable === 1'b1) me_seen++;
    model_check();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    bus.clear = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sec",     32'(bus.sec_count),  32'd0);
    chk("rst_me",      32'(bus.min_enable), 32'd0);
    chk("rst_clr",     32'(bus.clear_out),  32'd0);
    chk("rst_running", 32'(bus.running),    32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Count from idle, then wrap
    idle(3);
    step(1'b1, 1'b0, 1'b0);
    chk("start_running", 32'(bus.running), 32'd1);
    chk("start_sec0", 32'(bus.sec_count), 32'd0);
    idle(4);
    chk("sec_after_4", 32'(bus.sec_count), 32'd1);
    idle(4);
    chk("sec_after_8", 32'(bus.sec_count), 32'd2);
    idle(228);
    chk("no_wrap_by_236", 32'(me_seen), 32'd0);
    idle(3);
    chk("sec_at_239", 32'(bus.sec_count), 32'd59);
    idle(1);
    chk("wrap_sec0", 32'(bus.sec_count), 32'd0);
    chk("wrap_me", 32'(bus.min_enable), 32'd1);
    idle(1);
    chk("wrap_me_one_cycle", 32'(bus.min_enable), 32'd0);
    chk("minutes_read_1", 32'(me_seen), 32'd1);

    // Pause preserves the partial second
    step(1'b0, 1'b0, 1'b1);
    chk("clear_pulse", 32'(bus.clear_out), 32'd1);
    idle(1);
    chk("clear_one_cycle", 32'(bus.clear_out), 32'd0);
    step(1'b1, 1'b0, 1'b0);
    idle(6);
    step(1'b0, 1'b1, 1'b0);
    chk("pause_sec1", 32'(bus.sec_count), 32'd1);
    idle(20);
    chk("pause_hold_sec1", 32'(bus.sec_count), 32'd1);
    chk("pause_not_running", 32'(bus.running), 32'd0);
    step(1'b1, 1'b0, 1'b0);
    idle(1);
    chk("resume_sec1", 32'(bus.sec_count), 32'd1);
    idle(1);
    chk("resume_sec2", 32'(bus.sec_count), 32'd2);

    // start+stop while RUNNING: stop wins
    step(1'b1, 1'b1, 1'b0);
    chk("startstop_run_paused", 32'(bus.running), 32'd0);
    // Reach sec 30 (elapsed 120), pause, then start+stop in PAUSED resumes
    step(1'b1, 1'b0, 1'b0);
    idle(112);
    step(1'b0, 1'b1, 1'b0);
    chk("paused_sec30", 32'(bus.sec_count), 32'd30);
    step(1'b1, 1'b1, 1'b0);
    chk("startstop_paused_runs", 32'(bus.running), 32'd1);
    step(1'b0, 1'b1, 1'b0);
    // clear+start while PAUSED at 30
    step(1'b1, 1'b0, 1'b1);
    chk("clrstart_sec0", 32'(bus.sec_count), 32'd0);
    chk("clrstart_clr", 32'(bus.clear_out), 32'd1);
    chk("clrstart_idle", 32'(bus.running), 32'd0);
    idle(3);
    chk("clrstart_stays_idle", 32'(bus.running), 32'd0);

    // stop on the edge a tick would fire: tick deferred to after resume
    step(1'b1, 1'b0, 1'b0);
    idle(3);
    step(1'b0, 1'b1, 1'b0);
    chk("stop_at_tick_sec0", 32'(bus.sec_count), 32'd0);
    step(1'b1, 1'b0, 1'b0);
    chk("resume_no_tick_yet", 32'(bus.sec_count), 32'd0);
    idle(1);
    chk("deferred_tick", 32'(bus.sec_count), 32'd1);

    // clear on the wrap edge
    idle(235);
    chk("pre_wrap_sec59", 32'(bus.sec_count), 32'd59);
    step(1'b0, 1'b0, 1'b1);
    chk("clrwrap_me", 32'(bus.min_enable), 32'd0);
    chk("clrwrap_clr", 32'(bus.clear_out), 32'd1);
    chk("clrwrap_sec", 32'(bus.sec_count), 32'd0);

    // Random command traffic against the model
    for (int i = 0; i < 1500; i++) begin
      step(1'($urandom_range(0, 99) < 6),
           1'($urandom_range(0, 99) < 3),
           1'($urandom_range(0, 199) < 1));
    end

    // Async reset mid-run at sec 45
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    idle(180);
    chk("pre_reset_sec45", 32'(bus.sec_count), 32'd45);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_sec", 32'(bus.sec_count), 32'd0);
    chk("arst_me", 32'(bus.min_enable), 32'd0);
    chk("arst_clr", 32'(bus.clear_out), 32'd0);
    chk("arst_running", 32'(bus.running), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(6);
    chk("post_reset_idle", 32'(bus.running), 32'd0);
    step(1'b1, 1'b0, 1'b0);
    idle(4);
    chk("post_reset_count", 32'(bus.sec_count), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
